// File: rtl/disp_mux4_if.sv
// Display multiplexer bus: digit data/control from the host, scanned
// anode/segment-select outputs toward the 7-segment decoder.
interface disp_mux4_if;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output data, load, dp_in, blank_lz,
    input  digit, an, dp
  );

  modport slave (
    input  data, load, dp_in, blank_lz,
    output digit, an, dp
  );
endinterface

// File: rtl/disp_mux4.sv
// Four-digit time-multiplexed display driver with leading-zero blanking.
// Each slot is shown for CLK_DIV clocks; outputs change only on the slot tick.
module disp_mux4 #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  disp_mux4_if.slave bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    dpr_q, dpr_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic [3:0]    hi_zero;
  logic          blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd3;
      data_q  <= 16'h0000;
      dpr_q   <= 4'b0000;
      digit_q <= 4'h0;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dpr_q   <= dpr_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  // Blanking and display use the pre-load holding registers, so a load that
  // coincides with a tick only becomes visible on the following tick.
  always_comb begin
    tick    = (presc_q == PRE_TC);
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    data_d  = bus.load ? bus.data  : data_q;
    dpr_d   = bus.load ? bus.dp_in : dpr_q;

    hi_zero[3] = (data_q[15:12] == 4'h0);
    hi_zero[2] = hi_zero[3] && (data_q[11:8] == 4'h0);
    hi_zero[1] = hi_zero[2] && (data_q[7:4] == 4'h0);
    hi_zero[0] = 1'b0;
    blank      = bus.blank_lz && hi_zero[idx_d] && !dpr_q[idx_d];

    digit_d = digit_q;
    an_d    = an_q;
    dp_d    = dp_q;
    if (tick) begin
      if (blank) begin
        digit_d = 4'h0;
        an_d    = 4'b1111;
        dp_d    = 1'b1;
      end else begin
        digit_d = data_q[{idx_d, 2'b00} +: 4];
        an_d    = ~(4'b0001 << idx_d);
        dp_d    = ~dpr_q[idx_d];
      end
    end
  end

  assign bus.digit = digit_q;
  assign bus.an    = an_q;
  assign bus.dp    = dp_q;

endmodule

// File: tb/tb_disp_mux4.sv
// Directed bench for disp_mux4 at CLK_DIV=4: scan order, hold time, blanking,
// decimal points, load/tick collision and mid-scan reset.
module tb_disp_mux4;

  logic clk;
  logic rst;
  disp_mux4_if bus();

  disp_mux4 #(.CLK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  logic [3:0] e_an  [4];
  logic [3:0] e_dig [4];
  logic       e_dp  [4];

  // an must be all-high or exactly one bit low at every cycle
  always @(negedge clk) begin
    n_cmp++;
    assert (bus.an === 4'b1111 || bus.an === 4'b1110 || bus.an === 4'b1101 ||
            bus.an === 4'b1011 || bus.an === 4'b0111)
    else begin
      n_err++;
      $error("FAIL an_onehot: observed %b expected one-hot-low or 1111", bus.an);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check(input string tag, input logic [3:0] an,
                       input logic [3:0] dig, input logic dp);
    n_cmp++;
    assert (bus.an === an) else begin
      n_err++;
      $error("FAIL %s an (edge %0d): observed %b expected %b", tag, edge_n, bus.an, an);
    end
    n_cmp++;
    assert (bus.digit === dig) else begin
      n_err++;
      $error("FAIL %s digit (edge %0d): observed %h expected %h", tag, edge_n, bus.digit, dig);
    end
    n_cmp++;
    assert (bus.dp === dp) else begin
      n_err++;
      $error("FAIL %s dp (edge %0d): observed %b expected %b", tag, edge_n, bus.dp, dp);
    end
  endtask

  // Nibble n of each argument describes slot n.
  task automatic set_exp(input logic [15:0] an4, input logic [15:0] dig4,
                         input logic [3:0] dp4);
    for (int s = 0; s < 4; s++) begin
      e_an[s]  = an4[4*s +: 4];
      e_dig[s] = dig4[4*s +: 4];
      e_dp[s]  = dp4[s];
    end
  endtask

  // First tick lands on edge 4 after reset release and shows slot 0.
  task automatic scan(input string tag, input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      step();
      if (edge_n < 4) begin
        check(tag, 4'b1111, 4'h0, 1'b1);
      end else begin
        s = ((edge_n / 4) - 1) % 4;
        check(tag, e_an[s], e_dig[s], e_dp[s]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", 4'b1111, 4'h0, 1'b1);
    step();
    check("rst_hold", 4'b1111, 4'h0, 1'b1);
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p, input string tag);
    bus.data  = d;
    bus.dp_in = p;
    bus.load  = 1'b1;
    scan(tag, 1);
    bus.load  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.data     = 16'h0000;
    bus.load     = 1'b0;
    bus.dp_in    = 4'b0000;
    bus.blank_lz = 1'b0;

    // Plain scan of 1234, two full rounds, every cycle checked
    do_reset();
    set_exp(16'h7BDE, 16'h1234, 4'hF);
    load_word(16'h1234, 4'b0000, "scan1234");
    scan("scan1234", 34);

    // Leading-zero blanking of 0050, then all-zero word
    do_reset();
    bus.blank_lz = 1'b1;
    set_exp(16'hFFDE, 16'h0050, 4'hF);
    load_word(16'h0050, 4'b0000, "blank0050");
    scan("blank0050", 18);
    do_reset();
    set_exp(16'hFFFE, 16'h0000, 4'hF);
    load_word(16'h0000, 4'b0000, "blank0000");
    scan("blank0000", 18);

    // Decimal point on slot 2 keeps it lit under blanking
    do_reset();
    set_exp(16'hFBFE, 16'h0000, 4'b1011);
    load_word(16'h0000, 4'b0100, "dp_slot2");
    scan("dp_slot2", 18);
    bus.blank_lz = 1'b0;

    // Load coincident with the tick into slot 1, then a mid-slot load in slot 2
    do_reset();
    set_exp(16'h7BDE, 16'h1234, 4'hF);
    load_word(16'h1234, 4'b0000, "coll_pre");
    scan("coll_pre", 6);
    load_word(16'hABCD, 4'b0000, "coll_tick");
    scan("coll_hold", 3);
    set_exp(16'h7BDE, 16'hABCD, 4'hF);
    scan("coll_next", 2);
    set_exp(16'h7BDE, 16'h5B78, 4'hF);
    load_word(16'h5678, 4'b0000, "midslot_load");
    scan("midslot_after", 9);

    // Reset pulse during slot 2: immediate blank, restart at slot 0 showing 0
    do_reset();
    set_exp(16'h7BDE, 16'h1234, 4'hF);
    load_word(16'h1234, 4'b0000, "prerst");
    scan("prerst", 12);
    check("prerst_slot2", 4'b1011, 4'h2, 1'b1);
    do_reset();
    set_exp(16'h7BDE, 16'h0000, 4'hF);
    scan("postrst", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_mux4.md
DISP_MUX4 -- requirements
Module: disp_mux4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter CLK_DIV, default 50000, SHALL set the number of clk cycles each digit slot is displayed (legal range 2..2^24).
REQ-003 Port clk, input, 1 bit: system clock, rising-edge active.
REQ-004 Port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 Port data, input, 16 bits: four hex digits; slot0 = data[3:0] and slot3 = data[15:12].
REQ-006 Port load, input, 1 bit: capture data and dp_in into the holding registers.
REQ-007 Port dp_in, input, 4 bits: decimal-point request per slot, active-high, with bit n for slot n.
REQ-008 Port blank_lz, input, 1 bit: enable leading-zero blanking; sampled at each tick, not latched by load.
REQ-009 Port digit, output, 4 bits: nibble for the active slot; this drives the 4-bit input of the 7-segment decoder.
REQ-010 Port an, output, 4 bits: anode enables, active-low, with bit n for slot n.
REQ-011 Port dp, output, 1 bit: decimal point, active-low.

Function
REQ-012 The block SHALL contain a prescaler counter that runs 0..CLK_DIV-1 and wraps to 0.
REQ-013 The prescaler width SHALL be $clog2(CLK_DIV).
REQ-014 The block SHALL assert an internal one-cycle tick on the cycle where the prescaler equals CLK_DIV-1.
REQ-015 The block SHALL contain a slot index idx (2 bits); on each tick, idx <= idx+1 mod 4 (sequence 3->0->1->2->3).
REQ-016 The holding registers data_r (16 bits) and dp_r (4 bits) SHALL load on any clk edge with load=1; when load=0 they SHALL hold.
REQ-017 On a tick edge, the outputs SHALL be registered from the new idx: digit <= data_r nibble[new idx]; an <= all ones except bit[new idx]=0; dp <= ~dp_r[new idx].
REQ-018 Between ticks, digit, an and dp SHALL NOT change; a load mid-slot SHALL NOT alter the displayed outputs until the next tick.
REQ-019 If load and tick occur on the same edge, the tick SHALL use the old data_r/dp_r; the new values SHALL appear from the following tick.
REQ-020 Leading-zero blanking applies only when blank_lz=1 at the tick.
REQ-021 Under blanking, slot n (n>=1) SHALL be blanked if its nibble and all higher nibbles of data_r are zero.
REQ-022 A blanked slot SHALL drive an=4'b1111, digit=4'h0 and dp=1, unless dp_r[n]=1, in which case the slot is not blanked.
REQ-023 Slot 0 SHALL never be blanked.
REQ-024 At most one an bit SHALL be low in any cycle.
REQ-025 idx SHALL advance even when the slot is blanked (constant refresh rate).
REQ-026 Total latency from a load edge to display SHALL be at most 4*CLK_DIV cycles for every slot.

Reset
REQ-027 While rst=1, regardless of clk: prescaler=0, idx=3, data_r=16'h0000, dp_r=4'b0000, digit=4'h0, an=4'b1111, dp=1.
REQ-028 After rst deasserts, the first tick SHALL occur CLK_DIV edges later and SHALL show slot 0.
REQ-029 A reset asserted mid-scan SHALL blank the display immediately (asynchronously), and the scan SHALL restart from slot 0 per REQ-028.

Verification (CLK_DIV=4, blank_lz=0 unless stated)
REQ-030 Reset release, then load data=16'h1234 on the first edge -> an/digit = 1110/4, 1101/3, 1011/2, 0111/1, then repeat; each value is held exactly 4 cycles.
REQ-031 blank_lz=1, data=16'h0050 -> slots 3 and 2: an=1111; slot 1: an=1101, digit 5; slot 0: an=1110, digit 0. With data=16'h0000, only slot 0 lights, showing 0.
REQ-032 dp_in=4'b0100 with data=16'h0000 and blank_lz=1 -> slot 2 is lit with digit 0 and dp=0; slot 3 is blanked; dp=1 in all other slots.
REQ-033 Load 16'hABCD coincident with the tick to slot 1 (old data 16'h1234) -> slot 1 shows 3; slot 2 then shows B.
REQ-034 Assert rst for 1 cycle during slot 2 -> an=1111 and digit=0 in the same cycle; the next lit slot is slot 0 after 4 cycles; data_r is cleared, so it shows 0.
REQ-035 Throughout all scenarios, a checker SHALL confirm an is never other than one-hot-low or 4'b1111.
